// File: rtl/x87_stack_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : x87_stack_ctrl
// Brief    : x87 register-stack controller. Tracks TOP and the tag bits and
//            sequences commands to the datapath with a bounded handshake.
//            Optional stack fault checking is enabled by X87_STACK_CHECK_EN.
// Revision : 1.0 - initial release
// =============================================================================
module x87_stack_ctrl #(
    parameter logic [7:0] EXE_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  cmd_in,
    input  logic [2:0]  idx_in,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    output logic        exe_req,
    output logic [4:0]  exe_op,
    output logic [2:0]  exe_src,
    output logic [2:0]  exe_dst,
    input  logic        exe_ack,
    input  logic [1:0]  exe_cmp,
    output logic [2:0]  top,
    output logic [7:0]  tag,
    output logic [15:0] sw,
    output logic        timeout
);

    localparam logic [4:0] CMD_NOP       = 5'd0;
    localparam logic [4:0] CMD_FNSTSW_AX = 5'd1;
    localparam logic [4:0] CMD_FNINIT    = 5'd2;
    localparam logic [4:0] CMD_FLDCW     = 5'd3;
    localparam logic [4:0] CMD_FNSTCW    = 5'd4;
    localparam logic [4:0] CMD_FWAIT     = 5'd5;
    localparam logic [4:0] CMD_FLD_M32   = 5'd6;
    localparam logic [4:0] CMD_FLD_M64   = 5'd7;
    localparam logic [4:0] CMD_FSTP_M32  = 5'd8;
    localparam logic [4:0] CMD_FSTP_M64  = 5'd9;
    localparam logic [4:0] CMD_FLD_STI   = 5'd10;
    localparam logic [4:0] CMD_FXCH_STI  = 5'd11;
    localparam logic [4:0] CMD_FSTP_STI  = 5'd12;
    localparam logic [4:0] CMD_FADD      = 5'd20;
    localparam logic [4:0] CMD_FMUL      = 5'd21;
    localparam logic [4:0] CMD_FDIV      = 5'd22;
    localparam logic [4:0] CMD_FCOM      = 5'd23;
    localparam logic [4:0] CMD_FSUB      = 5'd24;
    localparam logic [4:0] CMD_FSUBR     = 5'd25;
    localparam logic [4:0] CMD_FCOMP     = 5'd26;
    localparam logic [4:0] CMD_FADDP     = 5'd27;
    localparam logic [4:0] CMD_FMULP     = 5'd28;
    localparam logic [4:0] CMD_FDIVP     = 5'd29;
    localparam logic [4:0] CMD_OTHER     = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cmd_q;
    logic [2:0]  idx_q;
    logic [7:0]  exe_cnt;
    logic        sw_c3;
    logic [10:0] sw_lo;

    logic [2:0]  phys_i;
    logic [2:0]  push_slot;
    logic [7:0]  tag_popped;
    logic        is_push;
    logic        is_pop;
    logic        is_cmp;
    logic        sti_form;
    logic        dst_sti;
    logic        no_exe;
    logic        ovf;
    logic        unf;
    logic        tmo_hit;

    assign phys_i        = top + idx_q;
    assign push_slot     = top - 3'd1;
    assign cmd_ready_out = (state == ST_IDLE);
    assign sw            = {1'b0, sw_c3, top, sw_lo};
    assign tmo_hit       = (EXE_TIMEOUT != 8'd0) && (exe_cnt == EXE_TIMEOUT - 8'd1);

    // FSTP ST(i) writes its target before ST0 is released, so idx=0 is a plain pop.
    assign tag_popped = ((cmd_q == CMD_FSTP_STI) ? (tag | (8'd1 << phys_i)) : tag)
                        & ~(8'd1 << top);

    always_comb begin
        is_push  = 1'b0;
        is_pop   = 1'b0;
        is_cmp   = 1'b0;
        sti_form = 1'b0;
        dst_sti  = 1'b0;
        no_exe   = 1'b0;
        case (cmd_q)
            CMD_NOP, CMD_FNINIT, CMD_FWAIT, CMD_OTHER: no_exe = 1'b1;
            CMD_FNSTSW_AX, CMD_FLDCW, CMD_FNSTCW: ;
            CMD_FLD_M32, CMD_FLD_M64: is_push = 1'b1;
            CMD_FLD_STI: begin
                is_push  = 1'b1;
                sti_form = 1'b1;
            end
            CMD_FSTP_M32, CMD_FSTP_M64: is_pop = 1'b1;
            CMD_FXCH_STI: sti_form = 1'b1;
            CMD_FSTP_STI, CMD_FADDP, CMD_FMULP, CMD_FDIVP: begin
                is_pop   = 1'b1;
                sti_form = 1'b1;
                dst_sti  = 1'b1;
            end
            CMD_FADD, CMD_FMUL, CMD_FDIV, CMD_FSUB, CMD_FSUBR: sti_form = 1'b1;
            CMD_FCOM: begin
                is_cmp   = 1'b1;
                sti_form = 1'b1;
            end
            CMD_FCOMP: begin
                is_cmp   = 1'b1;
                is_pop   = 1'b1;
                sti_form = 1'b1;
            end
            default: no_exe = 1'b1;
        endcase
    end

`ifdef X87_STACK_CHECK_EN
    logic need_st0;
    logic need_sti;

    always_comb begin
        need_st0 = 1'b0;
        need_sti = 1'b0;
        case (cmd_q)
            CMD_FLD_STI: need_sti = 1'b1;
            CMD_FSTP_M32, CMD_FSTP_M64, CMD_FSTP_STI: need_st0 = 1'b1;
            CMD_FXCH_STI, CMD_FADD, CMD_FMUL, CMD_FDIV, CMD_FCOM, CMD_FSUB,
            CMD_FSUBR, CMD_FCOMP, CMD_FADDP, CMD_FMULP, CMD_FDIVP: begin
                need_st0 = 1'b1;
                need_sti = 1'b1;
            end
            default: ;
        endcase
    end

    // Overflow wins when a push would both overflow and read an empty ST(i).
    assign ovf = is_push & tag[push_slot];
    assign unf = ~ovf & ((need_st0 & ~tag[top]) | (need_sti & ~tag[phys_i]));
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid_in) state_nx = ST_CHECK;
            end
            ST_CHECK: begin
                if (ovf | unf)   state_nx = ST_IDLE;
                else if (no_exe) state_nx = ST_COMMIT;
                else             state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                if (exe_ack)      state_nx = ST_COMMIT;
                else if (tmo_hit) state_nx = ST_IDLE;
            end
            ST_COMMIT: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= 5'd0;
            idx_q   <= 3'd0;
            exe_req <= 1'b0;
            exe_op  <= 5'd0;
            exe_src <= 3'd0;
            exe_dst <= 3'd0;
            exe_cnt <= 8'd0;
            timeout <= 1'b0;
            top     <= 3'd0;
            tag     <= 8'h00;
            sw_c3   <= 1'b0;
            sw_lo   <= 11'd0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_in) begin
                        cmd_q <= cmd_in;
                        idx_q <= idx_in;
                    end
                end
                ST_CHECK: begin
                    exe_cnt <= 8'd0;
                    if (ovf | unf) begin
                        sw_lo[0] <= 1'b1;
                        sw_lo[6] <= 1'b1;
                        sw_lo[7] <= 1'b1;
                        sw_lo[9] <= ovf;
                    end else if (!no_exe) begin
                        exe_req <= 1'b1;
                        exe_op  <= cmd_q;
                        exe_src <= sti_form ? phys_i : top;
                        exe_dst <= is_push ? push_slot : (dst_sti ? phys_i : top);
                    end
                end
                ST_EXEC: begin
                    if (exe_ack) begin
                        exe_req <= 1'b0;
                    end else if (tmo_hit) begin
                        exe_req  <= 1'b0;
                        timeout  <= 1'b1;
                        sw_lo[7] <= 1'b1;
                    end else begin
                        exe_cnt <= exe_cnt + 8'd1;
                    end
                end
                ST_COMMIT: begin
                    if (cmd_q == CMD_FNINIT) begin
                        top   <= 3'd0;
                        tag   <= 8'h00;
                        sw_c3 <= 1'b0;
                        sw_lo <= 11'd0;
                    end else begin
                        if (is_push) begin
                            top            <= push_slot;
                            tag[push_slot] <= 1'b1;
                        end else if (is_pop) begin
                            top <= top + 3'd1;
                            tag <= tag_popped;
                        end
                        // exe_cmp: 00 gt, 01 lt, 10 eq, 11 unordered -> C3,C2,C0
                        if (is_cmp) begin
                            sw_c3     <= exe_cmp[1];
                            sw_lo[10] <= &exe_cmp;
                            sw_lo[8]  <= exe_cmp[0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_x87_stack_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_x87_stack_ctrl
// Brief    : Self-checking bench for x87_stack_ctrl: directed scenarios plus
//            randomized commands against a stack-level reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_x87_stack_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  cmd_in = 5'd0;
    logic [2:0]  idx_in = 3'd0;
    logic        cmd_valid_in = 1'b0;
    logic        cmd_ready_out;
    logic        exe_req;
    logic [4:0]  exe_op;
    logic [2:0]  exe_src;
    logic [2:0]  exe_dst;
    logic        exe_ack = 1'b0;
    logic [1:0]  exe_cmp = 2'd0;
    logic [2:0]  top;
    logic [7:0]  tag;
    logic [15:0] sw;
    logic        timeout;

    always #5 clk = ~clk;

    x87_stack_ctrl #(.EXE_TIMEOUT(8'd4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_in        (cmd_in),
        .idx_in        (idx_in),
        .cmd_valid_in  (cmd_valid_in),
        .cmd_ready_out (cmd_ready_out),
        .exe_req       (exe_req),
        .exe_op        (exe_op),
        .exe_src       (exe_src),
        .exe_dst       (exe_dst),
        .exe_ack       (exe_ack),
        .exe_cmp       (exe_cmp),
        .top           (top),
        .tag           (tag),
        .sw            (sw),
        .timeout       (timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: stack as TOP plus a validity flag per physical register.
    int m_top;
    bit m_valid[8];
    bit m_ie, m_sf, m_es, m_c0, m_c1, m_c2, m_c3;

    function automatic void model_reset();
        m_top = 0;
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        {m_ie, m_sf, m_es, m_c0, m_c1, m_c2, m_c3} = '0;
    endfunction

    function automatic int phys(input int i);
        return (m_top + i) % 8;
    endfunction

    function automatic logic [7:0] exp_tag();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = m_valid[i];
        return t;
    endfunction

    function automatic logic [15:0] exp_sw();
        return {1'b0, m_c3, 3'(m_top), m_c2, m_c1, m_c0, m_es, m_sf, 5'd0, m_ie};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cmd_valid_in = 1'b0;
        exe_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Issue one command; delay = EXEC cycles before ack (>= TO means no ack).
    task automatic run_cmd(input int cmd, input int idx, input int delay, input logic [1:0] cmpv);
        int  slot, kind, e_src, e_dst, e_req_n, e_ready_at;
        int  req_n, tmo_n, ready_at;
        bit  ovf, unf, acked, push;
        for (int w = 0; w < 50 && !cmd_ready_out; w++) @(negedge clk);
        if (!cmd_ready_out) begin
            check_eq("ready_wait", 32'(cmd_ready_out), 32'd1);
            return;
        end

        slot = (m_top + 7) % 8;
        push = (cmd == 6 || cmd == 7 || cmd == 10);
        ovf  = 1'b0;
        unf  = 1'b0;
`ifdef X87_STACK_CHECK_EN
        if (push && m_valid[slot]) ovf = 1'b1;
        else begin
            if (cmd == 10 && !m_valid[phys(idx)]) unf = 1'b1;
            if ((cmd == 8 || cmd == 9 || cmd == 12) && !m_valid[phys(0)]) unf = 1'b1;
            if ((cmd == 11 || (cmd >= 20 && cmd <= 29)) &&
                (!m_valid[phys(0)] || !m_valid[phys(idx)])) unf = 1'b1;
        end
`endif
        if (ovf || unf) kind = 0;
        else if (cmd == 0 || cmd == 2 || cmd == 5 || cmd == 31) kind = 1;
        else kind = 2;
        e_src = (cmd >= 10 && cmd <= 12) || (cmd >= 20 && cmd <= 29) ? phys(idx) : phys(0);
        e_dst = push ? slot : ((cmd == 12 || cmd >= 27 && cmd <= 29) ? phys(idx) : phys(0));
        acked = (kind == 2) && (delay < TO);
        e_req_n    = (kind != 2) ? 0 : (acked ? delay + 1 : TO);
        e_ready_at = (kind == 0) ? 2 : (kind == 1) ? 3 : (acked ? 4 + delay : 2 + TO);

        cmd_in = 5'(cmd);
        idx_in = 3'(idx);
        exe_cmp = cmpv;
        cmd_valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_in = 1'b0;
        cmd_in = 5'($urandom);
        idx_in = 3'($urandom);
        req_n = 0;
        tmo_n = 0;
        ready_at = 0;
        for (int n = 1; n <= 30; n++) begin
            if (n > 1) @(negedge clk);
            if (timeout) tmo_n++;
            if (exe_req) begin
                req_n++;
                if (req_n == 1) begin
                    check_eq("exe_op", 32'(exe_op), 32'(cmd));
                    check_eq("exe_src", 32'(exe_src), 32'(e_src));
                    check_eq("exe_dst", 32'(exe_dst), 32'(e_dst));
                end
                exe_ack = (req_n - 1 == delay);
            end else begin
                exe_ack = 1'($urandom);
            end
            if (cmd_ready_out) begin
                ready_at = n;
                break;
            end
        end
        exe_ack = 1'b0;
        check_eq("ready_latency", 32'(ready_at), 32'(e_ready_at));
        check_eq("exe_req_cycles", 32'(req_n), 32'(e_req_n));
        check_eq("timeout_pulse", 32'(tmo_n), (kind == 2 && !acked) ? 32'd1 : 32'd0);

        if (kind == 0) begin
            m_ie = 1'b1; m_sf = 1'b1; m_es = 1'b1; m_c1 = ovf;
        end else if (kind == 2 && !acked) begin
            m_es = 1'b1;
        end else begin
            case (cmd)
                2: model_reset();
                6, 7, 10: begin
                    m_valid[slot] = 1'b1;
                    m_top = slot;
                end
                8, 9, 26, 27, 28, 29: begin
                    m_valid[phys(0)] = 1'b0;
                    m_top = (m_top + 1) % 8;
                end
                12: begin
                    m_valid[phys(idx)] = 1'b1;
                    m_valid[phys(0)] = 1'b0;
                    m_top = (m_top + 1) % 8;
                end
                default: ;
            endcase
            if (cmd == 23 || cmd == 26) begin
                case (cmpv)
                    2'b00: {m_c3, m_c2, m_c0} = 3'b000;
                    2'b01: {m_c3, m_c2, m_c0} = 3'b001;
                    2'b10: {m_c3, m_c2, m_c0} = 3'b100;
                    default: {m_c3, m_c2, m_c0} = 3'b111;
                endcase
            end
        end
        check_eq("top", 32'(top), 32'(m_top));
        check_eq("tag", 32'(tag), 32'(exp_tag()));
        check_eq("sw", 32'(sw), 32'(exp_sw()));
    endtask

    int ops[24] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12,
                    20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 31};

    initial begin
        int r, c, d;
        model_reset();
        do_reset();
        check_eq("rst_top", 32'(top), 32'd0);
        check_eq("rst_tag", 32'(tag), 32'h00);
        check_eq("rst_sw", 32'(sw), 32'h0000);
        check_eq("rst_ready", 32'(cmd_ready_out), 32'd1);
        check_eq("rst_req", 32'(exe_req), 32'd0);
        check_eq("rst_exe_op", 32'({exe_op, exe_src, exe_dst, timeout}), 32'd0);

        run_cmd(6, 0, 2, 2'b00);
        check_eq("push_top", 32'(top), 32'd7);
        check_eq("push_tag", 32'(tag), 32'h80);
        check_eq("push_sw", 32'(sw), 32'h3800);

`ifdef X87_STACK_CHECK_EN
        run_cmd(20, 1, 0, 2'b00);
        check_eq("unf_sw_lo", 32'(sw[7:0]), 32'hC1);
        check_eq("unf_c1", 32'(sw[9]), 32'd0);
        check_eq("unf_top", 32'(top), 32'd7);
        check_eq("unf_tag", 32'(tag), 32'h80);
`endif

        do_reset();
        for (int i = 0; i < 8; i++) run_cmd(6, 0, 0, 2'b00);
        run_cmd(7, 0, 1, 2'b00);
        check_eq("full_tag", 32'(tag), 32'hFF);
`ifdef X87_STACK_CHECK_EN
        check_eq("ovf_flags", 32'(sw & 16'h02C1), 32'h02C1);
`endif

        do_reset();
        run_cmd(6, 0, 0, 2'b00);
        run_cmd(7, 0, 1, 2'b00);
        run_cmd(26, 1, 1, 2'b10);
        check_eq("fcomp_c3", 32'(sw[14]), 32'd1);
        check_eq("fcomp_c2", 32'(sw[10]), 32'd0);
        check_eq("fcomp_c0", 32'(sw[8]), 32'd0);
        check_eq("fcomp_top", 32'(top), 32'd7);
        check_eq("fcomp_tag", 32'(tag), 32'h80);

        // Asynchronous reset while a request is outstanding: nothing commits.
        cmd_in = 5'd6;
        cmd_valid_in = 1'b1;
        exe_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_in = 1'b0;
        @(negedge clk);
        check_eq("midexec_req_before", 32'(exe_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midexec_req", 32'(exe_req), 32'd0);
        check_eq("midexec_top_tag", 32'({top, tag}), 32'd0);
        check_eq("midexec_sw", 32'(sw), 32'd0);
        check_eq("midexec_ready", 32'(cmd_ready_out), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);

        run_cmd(6, 0, 10, 2'b00);
        check_eq("tmo_top", 32'(top), 32'd0);
        check_eq("tmo_tag", 32'(tag), 32'h00);
        check_eq("tmo_sw", 32'(sw), 32'h0080);

        // Ack in the last permitted EXEC cycle wins over the timeout.
        run_cmd(6, 0, TO - 1, 2'b00);

        do_reset();
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 4) c = 2;
            else if (r < 35) c = (r % 3 == 0) ? 10 : (r % 3 == 1 ? 6 : 7);
            else c = ops[$urandom_range(0, 23)];
            d = ($urandom_range(0, 99) < 15) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
            run_cmd(c, $urandom_range(0, 7), d, 2'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
